pc_fetch_ctrl: RTL and testbench
================================

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32, width of PC and all address ports.
REQ-002 Parameter DATA_WIDTH, default 32, width of immext and alu_result.
REQ-003 Parameter RESET_VECTOR, default 0, first fetch address after trigger.
REQ-004 The block SHALL use a single clock and a synchronous active-high reset, with ports as listed below.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 trigger  input  1  starts fetching from IDLE.
REQ-008 en_n  input  1  active-low PC enable; 1 = stall.
REQ-009 pcsrc  input  1  redirect request from execute stage.
REQ-010 jalr  input  1  qualifies pcsrc; 1 = register-relative target.
REQ-011 pc_e  input  ADDRESS_WIDTH  PC of the redirecting instruction.
REQ-012 immext  input  DATA_WIDTH  sign-extended immediate.
REQ-013 alu_result  input  DATA_WIDTH  jalr target before bit-0 clear.
REQ-014 halt  input  1  stop fetching.
REQ-015 pc  output  ADDRESS_WIDTH  current fetch address, registered.
REQ-016 pcplus4  output  ADDRESS_WIDTH  pc + 4, combinational.
REQ-017 valid  output  1  pc is a real fetch this cycle.
REQ-018 flush  output  1  combinational; redirect accepted this cycle.
REQ-019 misalign  output  1  sticky misaligned-target flag, registered.

Function
REQ-020 States: IDLE, RUN and HALTED, with a 2-bit encoded state register.
REQ-021 target = jalr ? (alu_result & ~1) truncated to ADDRESS_WIDTH : (pc_e + immext) mod 2^ADDRESS_WIDTH.
REQ-022 pcplus4 = (pc + 4) mod 2^ADDRESS_WIDTH, with wrap from all-ones-minus-3 to 0 and no error.
REQ-023 IDLE behaviour: pc holds, valid=0, flush=0, and en_n, pcsrc and halt are ignored.
REQ-024 IDLE with trigger=1: next state is RUN, pc stays RESET_VECTOR, and valid=1 from the next cycle.
REQ-025 RUN behaviour: valid=1; trigger is ignored.
REQ-026 RUN, pcsrc=1, target[1:0]!=0: misalign<=1, next state HALTED, pc holds, and flush=1.
REQ-027 RUN, pcsrc=1, aligned, en_n=0: pc<=target, flush=1, and any pending redirect is cleared.
REQ-028 RUN, pcsrc=1, aligned, en_n=1: pc holds, pend<=1, pend_tgt<=target, and flush=1.
REQ-029 A newer redirect overwrites an older pending one.
REQ-030 RUN, pcsrc=0, en_n=0, pend=1: pc<=pend_tgt and pend<=0.
REQ-031 RUN, pcsrc=0, en_n=0, pend=0: pc<=pcplus4.
REQ-032 RUN, pcsrc=0, en_n=1: pc and pend hold.
REQ-033 RUN, halt=1 with pcsrc=0: next state HALTED and pc holds.
REQ-034 RUN, halt=1 with pcsrc=1 aligned: the redirect is applied or pended per REQ-027/028 in the same edge, then the block enters HALTED.
REQ-035 HALTED behaviour: pc, pend and misalign hold; valid=0 and flush=0; all inputs except rst are ignored; only rst exits.
REQ-036 Reset latency: the first increment occurs on the second rising edge after trigger is sampled high.

Reset
REQ-037 On rst=1 at a rising edge: state<=IDLE, pc<=RESET_VECTOR, pend<=0, pend_tgt<=0, misalign<=0.
REQ-038 After reset: valid=0 and flush=0.
REQ-039 rst SHALL override trigger, pcsrc, halt and en_n in any state, including mid-stall with a pending redirect, which is discarded.

Verification
REQ-040 Scenario, start and count: rst; trigger pulse; en_n=0 for 4 cycles -> pc = 0, 0, 4, 8, 12 and valid goes 0 then 1.
REQ-041 Scenario, branch: pcsrc=1, jalr=0, pc_e=0x10, immext=0xFFFFFFF8, en_n=0 -> flush=1 and the next pc=0x08.
REQ-042 Scenario, jalr under stall: pc=0x20, en_n=1, pcsrc=1, jalr=1, alu_result=0x101, then en_n=1 for 2 more cycles, then en_n=0 -> pc holds 0x20 for 3 cycles, then pc=0x100.
REQ-043 Scenario, misalign: pcsrc=1, jalr=0, pc_e=0x0, immext=0x6 -> misalign=1, valid=0 next cycle; trigger and pcsrc are then ignored; rst clears misalign and pc=0.
REQ-044 Scenario, wrap and halt: pc=0xFFFFFFFC, en_n=0 -> pc=0x0; halt=1 -> valid=0 and pc frozen until rst.
REQ-045 Scenario, reset mid-pend: pend=1 with pend_tgt=0x40, rst=1 -> pc=RESET_VECTOR, state IDLE, and pend_tgt is never applied.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage program counter: IDLE/RUN/HALTED sequencing, redirect handling
// with a one-entry pending slot for redirects that arrive during a stall.
module pc_fetch_ctrl #(
  parameter int                         ADDRESS_WIDTH = 32,
  parameter int                         DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_VECTOR  = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     trigger,
  input  logic                     en_n,
  input  logic                     pcsrc,
  input  logic                     jalr,
  input  logic [ADDRESS_WIDTH-1:0] pc_e,
  input  logic [DATA_WIDTH-1:0]    immext,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  input  logic                     halt,
  output logic [ADDRESS_WIDTH-1:0] pc,
  output logic [ADDRESS_WIDTH-1:0] pcplus4,
  output logic                     valid,
  output logic                     flush,
  output logic                     misalign
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  logic [1:0]               r_state;
  logic [ADDRESS_WIDTH-1:0] r_pc;
  logic                     r_pend;
  logic [ADDRESS_WIDTH-1:0] r_pend_tgt;
  logic                     r_misalign;

  logic [ADDRESS_WIDTH-1:0] w_target;
  logic                     w_run;
  logic                     w_misal;

  // Branch immediates are already sign-extended; a signed cast keeps that
  // true if DATA_WIDTH is narrower than the address.
  always_comb begin
    w_target = '0;
    if (jalr) begin
      w_target    = ADDRESS_WIDTH'(alu_result);
      w_target[0] = 1'b0;
    end else begin
      w_target = pc_e + ADDRESS_WIDTH'($signed(immext));
    end
  end

  assign w_run    = (r_state == S_RUN);
  assign w_misal  = (w_target[1:0] != 2'b00);
  assign pc       = r_pc;
  assign pcplus4  = r_pc + ADDRESS_WIDTH'(3'd4);
  assign valid    = w_run;
  assign flush    = w_run & pcsrc;
  assign misalign = r_misalign;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_VECTOR;
      r_pend     <= 1'b0;
      r_pend_tgt <= '0;
      r_misalign <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (trigger) r_state <= S_RUN;
        end
        S_RUN: begin
          if (pcsrc) begin
            if (w_misal) begin
              r_misalign <= 1'b1;
              r_state    <= S_HALTED;
            end else if (!en_n) begin
              r_pc   <= w_target;
              r_pend <= 1'b0;
            end else begin
              r_pend     <= 1'b1;
              r_pend_tgt <= w_target;
            end
            if (halt) r_state <= S_HALTED;
          end else if (halt) begin
            r_state <= S_HALTED;
          end else if (!en_n) begin
            // A redirect that landed during the stall wins over sequential fetch.
            if (r_pend) begin
              r_pc   <= r_pend_tgt;
              r_pend <= 1'b0;
            end else begin
              r_pc <= pcplus4;
            end
          end
        end
        S_HALTED: ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: per-scenario tasks with hand-computed values.
module tb_pc_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst, trigger, en_n, pcsrc, jalr, halt;
  logic [31:0] pc_e, immext, alu_result;
  logic [31:0] pc, pcplus4;
  logic        valid, flush, misalign;

  int n_cmp = 0;
  int n_err = 0;

  pc_fetch_ctrl dut (
    .clk(clk), .rst(rst), .trigger(trigger), .en_n(en_n), .pcsrc(pcsrc),
    .jalr(jalr), .pc_e(pc_e), .immext(immext), .alu_result(alu_result),
    .halt(halt), .pc(pc), .pcplus4(pcplus4), .valid(valid), .flush(flush),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    trigger = 0; en_n = 0; pcsrc = 0; jalr = 0; halt = 0;
    pc_e = 0; immext = 0; alu_result = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic start_run();
    trigger = 1; tick(); trigger = 0;
  endtask

  task automatic test_reset();
    do_reset();
    pcsrc = 1; halt = 1; en_n = 0; #1;
    n_cmp++; if (pc !== 32'h0)   begin n_err++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", valid); end
    n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL idle_flush got %b exp 0", flush); end
    n_cmp++; if (misalign !== 1'b0) begin n_err++; $display("FAIL reset_misalign got %b exp 0", misalign); end
    n_cmp++; if (pcplus4 !== 32'h4) begin n_err++; $display("FAIL reset_pcplus4 got %h exp 4", pcplus4); end
    tick();
    n_cmp++; if (pc !== 32'h0 || valid !== 1'b0) begin n_err++; $display("FAIL idle_ignores pc %h valid %b exp 0/0", pc, valid); end
    idle_inputs();
  endtask

  task automatic test_count();
    logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    do_reset();
    start_run();
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (pc !== exp_pc[i] || valid !== 1'b1) begin n_err++; $display("FAIL count_%0d pc %h valid %b exp %h/1", i, pc, valid, exp_pc[i]); end
      if (i < 3) tick();
    end
    en_n = 1; tick();
    n_cmp++; if (pc !== 32'hC) begin n_err++; $display("FAIL stall_hold got %h exp c", pc); end
    en_n = 0;
  endtask

  task automatic test_branch();
    pcsrc = 1; jalr = 0; pc_e = 32'h10; immext = 32'hFFFF_FFF8; en_n = 0; #1;
    n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL branch_flush got %b exp 1", flush); end
    tick(); pcsrc = 0;
    n_cmp++; if (pc !== 32'h8) begin n_err++; $display("FAIL branch_pc got %h exp 8", pc); end
  endtask

  task automatic test_jalr_stall();
    pcsrc = 1; jalr = 0; pc_e = 32'h20; immext = 0; tick();
    n_cmp++; if (pc !== 32'h20) begin n_err++; $display("FAIL to_20 got %h exp 20", pc); end
    en_n = 1; pcsrc = 1; jalr = 1; alu_result = 32'h101; #1;
    n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL jalr_flush got %b exp 1", flush); end
    tick(); pcsrc = 0; jalr = 0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (pc !== 32'h20) begin n_err++; $display("FAIL jalr_hold_%0d got %h exp 20", i, pc); end
      if (i < 2) tick();
    end
    en_n = 0; tick();
    n_cmp++; if (pc !== 32'h100) begin n_err++; $display("FAIL jalr_pend_pc got %h exp 100", pc); end
    // newer redirect overwrites older pending one
    en_n = 1; pcsrc = 1; pc_e = 32'h200; immext = 0; tick();
    pc_e = 32'h300; tick();
    pcsrc = 0; en_n = 0; tick();
    n_cmp++; if (pc !== 32'h300) begin n_err++; $display("FAIL pend_overwrite got %h exp 300", pc); end
    tick();
    n_cmp++; if (pc !== 32'h304) begin n_err++; $display("FAIL pend_cleared got %h exp 304", pc); end
  endtask

  task automatic test_misalign();
    do_reset(); start_run();
    pcsrc = 1; jalr = 0; pc_e = 32'h0; immext = 32'h6; #1;
    n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL misal_flush got %b exp 1", flush); end
    tick(); pcsrc = 0;
    n_cmp++; if (misalign !== 1'b1 || valid !== 1'b0 || pc !== 32'h0) begin n_err++; $display("FAIL misal_set mis %b valid %b pc %h exp 1/0/0", misalign, valid, pc); end
    trigger = 1; pcsrc = 1; pc_e = 32'h40; immext = 0; #1;
    n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL halted_flush got %b exp 0", flush); end
    tick(); tick();
    n_cmp++; if (misalign !== 1'b1 || valid !== 1'b0 || pc !== 32'h0) begin n_err++; $display("FAIL halted_ignore mis %b valid %b pc %h exp 1/0/0", misalign, valid, pc); end
    do_reset();
    n_cmp++; if (misalign !== 1'b0 || pc !== 32'h0) begin n_err++; $display("FAIL misal_clear mis %b pc %h exp 0/0", misalign, pc); end
  endtask

  task automatic test_wrap_halt();
    do_reset(); start_run();
    pcsrc = 1; pc_e = 32'hFFFF_FFF0; immext = 32'hC; tick(); pcsrc = 0;
    n_cmp++; if (pc !== 32'hFFFF_FFFC || pcplus4 !== 32'h0) begin n_err++; $display("FAIL wrap_pre pc %h p4 %h exp fffffffc/0", pc, pcplus4); end
    tick();
    n_cmp++; if (pc !== 32'h0 || misalign !== 1'b0) begin n_err++; $display("FAIL wrap_pc pc %h mis %b exp 0/0", pc, misalign); end
    halt = 1; tick(); halt = 0;
    n_cmp++; if (pc !== 32'h0 || valid !== 1'b0) begin n_err++; $display("FAIL halt pc %h valid %b exp 0/0", pc, valid); end
    trigger = 1; pcsrc = 1; pc_e = 32'h80; tick(); tick();
    n_cmp++; if (pc !== 32'h0 || valid !== 1'b0) begin n_err++; $display("FAIL halt_frozen pc %h valid %b exp 0/0", pc, valid); end
    idle_inputs();
  endtask

  task automatic test_halt_redirect();
    do_reset(); start_run();
    pcsrc = 1; pc_e = 32'h40; immext = 0; halt = 1; en_n = 0; tick();
    idle_inputs();
    n_cmp++; if (pc !== 32'h40 || valid !== 1'b0) begin n_err++; $display("FAIL halt_redirect pc %h valid %b exp 40/0", pc, valid); end
  endtask

  task automatic test_reset_mid_pend();
    do_reset(); start_run();
    en_n = 1; pcsrc = 1; pc_e = 32'h40; immext = 0; tick();
    pcsrc = 0; rst = 1; tick(); rst = 0;
    n_cmp++; if (pc !== 32'h0 || valid !== 1'b0) begin n_err++; $display("FAIL rst_pend pc %h valid %b exp 0/0", pc, valid); end
    en_n = 0; start_run(); tick();
    n_cmp++; if (pc !== 32'h4) begin n_err++; $display("FAIL pend_discarded got %h exp 4", pc); end
  endtask

  initial begin
    rst = 1; idle_inputs();
    test_reset();
    test_count();
    test_branch();
    test_jalr_stall();
    test_misalign();
    test_wrap_halt();
    test_halt_redirect();
    test_reset_mid_pend();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
